// File: rtl/sram_burst_controller.sv
// sram_burst_controller
// Bridges a DATA_W-bit memory-stage access onto a 16-bit asynchronous SRAM.
// Each access becomes DATA_W/16 halfword beats (least-significant halfword
// first). Writes honour byte enables. Reads assemble the beats into a shadow
// register before publishing the result. Addresses outside the SRAM window
// complete with an error pulse and never touch the SRAM pins.
module sram_burst_controller #(
    parameter int unsigned DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic                ready,
    output logic                err,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    localparam int unsigned BEATS     = DATA_W / 16;
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned SHIFT     = $clog2(BYTES);
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [63:0] SRAM_LAST = (64'd1 << SRAM_AW) - 64'd1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_WR_BEAT   = 3'd2;
    localparam logic [2:0] S_RD_ADDR   = 3'd3;
    localparam logic [2:0] S_RD_SAMPLE = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]         r_state;
    logic [31:0]        r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [BYTES-1:0]   r_be;
    logic               r_isWrite;
    logic [BEAT_W-1:0]  r_beat;
    logic [WAIT_W-1:0]  r_waitCnt;
    logic               r_flagErr;
    logic [SRAM_AW-1:0] r_base;
    logic [DATA_W-1:0]  r_shadow;
    logic [DATA_W-1:0]  r_readData;

    logic [31:0]        w_offset;
    logic [31:0]        w_idx;
    logic [63:0]        w_base;
    logic [63:0]        w_lastHw;
    logic               w_outOfRange;
    logic               w_lastBeat;
    logic [2:0]         w_afterBeats;
    logic               w_wrPhase;
    logic               w_rdPhase;
    logic [15:0]        w_halfword;
    logic [DATA_W-1:0]  w_readNext;

    // The range check works in 64 bits so a huge byte address cannot wrap
    // back into the valid halfword window.
    assign w_offset     = r_addr - BASE_ADDR;
    assign w_idx        = w_offset >> SHIFT;
    assign w_base       = {32'd0, w_idx} * 64'(BEATS);
    assign w_lastHw     = w_base + 64'(BEATS - 1);
    assign w_outOfRange = (r_addr < BASE_ADDR) || (w_lastHw > SRAM_LAST);

    assign w_lastBeat   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_afterBeats = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;

    // Strobes are gated by rst_n so an asserted reset drops WE_N/OE_N at once
    // and an interrupted beat is never committed by the SRAM.
    assign w_wrPhase  = rst_n && (r_state == S_WR_BEAT);
    assign w_rdPhase  = rst_n && ((r_state == S_RD_ADDR) || (r_state == S_RD_SAMPLE));
    assign w_halfword = r_wdata[{r_beat, 4'b0000} +: 16];

    assign SRAM_DQ   = w_wrPhase ? w_halfword : 16'hzzzz;
    assign SRAM_WE_N = ~w_wrPhase;
    assign SRAM_OE_N = ~w_rdPhase;
    assign SRAM_CE_N = ~(w_wrPhase | w_rdPhase);
    assign SRAM_LB_N = w_wrPhase ? ~r_be[{r_beat, 1'b0}] : ~w_rdPhase;
    assign SRAM_UB_N = w_wrPhase ? ~r_be[{r_beat, 1'b1}] : ~w_rdPhase;
    assign SRAM_ADDR = (w_wrPhase | w_rdPhase) ? (r_base + SRAM_AW'(r_beat)) : '0;

    assign ready     = (r_state == S_IDLE) ? ~(wr_en | rd_en) : (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_flagErr;
    assign read_data = r_readData;

    // Final read word: earlier beats come from the shadow, the last beat straight off the bus.
    always_comb begin
        w_readNext = r_shadow;
        w_readNext[DATA_W-1 -: 16] = SRAM_DQ;
    end

    // Access sequencer: latch request, range check, beat loop, settle wait, completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_isWrite  <= 1'b0;
            r_beat     <= '0;
            r_waitCnt  <= '0;
            r_flagErr  <= 1'b0;
            r_base     <= '0;
            r_shadow   <= '0;
            r_readData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_en || rd_en) begin
                        r_addr    <= address;
                        r_wdata   <= write_data;
                        r_be      <= byte_en;
                        r_isWrite <= wr_en;
                        r_beat    <= '0;
                        r_waitCnt <= '0;
                        r_flagErr <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_outOfRange) begin
                        r_flagErr <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_base  <= w_base[SRAM_AW-1:0];
                        r_state <= r_isWrite ? S_WR_BEAT : S_RD_ADDR;
                    end
                end
                S_WR_BEAT: begin
                    if (w_lastBeat) begin
                        r_state <= w_afterBeats;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_SAMPLE;
                end
                S_RD_SAMPLE: begin
                    r_shadow[{r_beat, 4'b0000} +: 16] <= SRAM_DQ;
                    if (w_lastBeat) begin
                        r_readData <= w_readNext;
                        r_state    <= w_afterBeats;
                    end else begin
                        r_beat  <= r_beat + 1'b1;
                        r_state <= S_RD_ADDR;
                    end
                end
                S_WAIT: begin
                    if (r_waitCnt == WAIT_W'(WAIT_LAST)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller
// Drives the 32-bit controller with directed and random accesses against a
// byte-addressed reference memory. A second 64-bit/no-wait instance covers
// the width variant. Each controller has its own simple SRAM pin model.
module tb_sram_burst_controller;

    localparam logic [31:0] BASE      = 32'd1024;
    localparam logic [31:0] SRAM_BYTES = 32'd524288;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generator.
    always #5 clk = ~clk;

    // 32-bit, WAIT_CYCLES=2 instance signals
    logic        wrEn, rdEn;
    logic [31:0] address, writeData, readData;
    logic [3:0]  byteEn;
    logic        ready, err;
    wire  [15:0] sramDq;
    logic [17:0] sramAddr;
    logic        weN, oeN, ceN, ubN, lbN;
    bit   [15:0] sram [0:262143];

    // 64-bit, WAIT_CYCLES=0 instance signals
    logic        wrEn64, rdEn64;
    logic [31:0] address64;
    logic [63:0] writeData64, readData64;
    logic [7:0]  byteEn64;
    logic        ready64, err64;
    wire  [15:0] sramDq64;
    logic [17:0] sramAddr64;
    logic        weN64, oeN64, ceN64, ubN64, lbN64;
    bit   [15:0] sram64 [0:15];

    // Bench bookkeeping and reference model
    int          checkCount = 0;
    int          passCount  = 0;
    logic [7:0]  refMem [int unsigned];
    logic [31:0] lastRead;
    logic [7:0]  lastWrLog;

    sram_burst_controller #(.DATA_W(32), .BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(18)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .rd_en(rdEn), .address(address),
        .write_data(writeData), .byte_en(byteEn), .read_data(readData), .ready(ready), .err(err),
        .SRAM_DQ(sramDq), .SRAM_ADDR(sramAddr), .SRAM_WE_N(weN), .SRAM_OE_N(oeN),
        .SRAM_CE_N(ceN), .SRAM_UB_N(ubN), .SRAM_LB_N(lbN)
    );

    sram_burst_controller #(.DATA_W(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0), .SRAM_AW(18)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn64), .rd_en(rdEn64), .address(address64),
        .write_data(writeData64), .byte_en(byteEn64), .read_data(readData64), .ready(ready64), .err(err64),
        .SRAM_DQ(sramDq64), .SRAM_ADDR(sramAddr64), .SRAM_WE_N(weN64), .SRAM_OE_N(oeN64),
        .SRAM_CE_N(ceN64), .SRAM_UB_N(ubN64), .SRAM_LB_N(lbN64)
    );

    // SRAM read side: drives the bus only while selected, output-enabled and not writing.
    assign sramDq   = (!ceN && !oeN && weN) ? sram[sramAddr] : 16'hzzzz;
    assign sramDq64 = (!ceN64 && !oeN64 && weN64) ? sram64[sramAddr64[3:0]] : 16'hzzzz;

    // SRAM write side: commits enabled byte lanes when WE_N is low at a clock edge.
    always @(posedge clk) begin
        if (!ceN && !weN) begin
            if (!lbN) sram[sramAddr][7:0]  <= sramDq[7:0];
            if (!ubN) sram[sramAddr][15:8] <= sramDq[15:8];
        end
        if (!ceN64 && !weN64) begin
            if (!lbN64) sram64[sramAddr64[3:0]][7:0]  <= sramDq64[7:0];
            if (!ubN64) sram64[sramAddr64[3:0]][15:8] <= sramDq64[15:8];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic bit refIsError(input logic [31:0] addr);
        logic [63:0] lastByte;
        if (addr < BASE) return 1'b1;
        lastByte = 64'((addr - BASE) & ~32'd3) + 64'd3;
        return lastByte >= 64'(SRAM_BYTES);
    endfunction

    function automatic logic [31:0] refRead(input int unsigned off);
        logic [31:0] word;
        for (int i = 0; i < 4; i++) begin
            word[8*i +: 8] = refMem.exists(off + i) ? refMem[off + i] : 8'h00;
        end
        return word;
    endfunction

    // One access on the 32-bit instance; samples strobes at every negedge until ready.
    task automatic applyStimulus(input bit isWr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, output int lat, output logic sawErr,
                                 output logic [31:0] rd, output int weLow, output int oeLow,
                                 output int ceLow, output int badBus, output logic [7:0] wrLog,
                                 output bit timedOut);
        lat = 0; weLow = 0; oeLow = 0; ceLow = 0; badBus = 0;
        wrLog = 8'h00; timedOut = 1'b0; sawErr = 1'b0; rd = '0;
        @(negedge clk);
        wrEn = isWr; rdEn = !isWr; address = addr; writeData = data; byteEn = be;
        @(posedge clk);
        #1;
        wrEn = 1'b0; rdEn = 1'b0;
        while (1) begin
            @(negedge clk);
            if (!weN) begin
                weLow++;
                wrLog = {wrLog[5:0], ubN, lbN};
            end
            if (!oeN) oeLow++;
            if (!ceN) ceLow++;
            if ((!weN && !oeN) || (!weN && ceN) || (!oeN && ceN)) badBus++;
            if (ready) begin
                sawErr = err;
                rd = readData;
                break;
            end
            if (lat >= 40) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    // Runs one access, updates the reference model and compares everything observable.
    task automatic runAccess(input string tag, input bit isWr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        int lat, weLow, oeLow, ceLow, badBus, expLat;
        bit timedOut, isErr;
        logic sawErr;
        logic [31:0] rd;
        logic [7:0] wrLog;
        int unsigned off;
        isErr = refIsError(addr);
        off = (addr - BASE) & ~32'd3;
        if (!isErr) begin
            if (isWr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) refMem[off + i] = data[8*i +: 8];
                end
            end else begin
                lastRead = refRead(off);
            end
        end
        expLat = isErr ? 1 : (isWr ? 1 + 2 + 2 : 1 + 2 * 2 + 2);
        applyStimulus(isWr, addr, data, be, lat, sawErr, rd, weLow, oeLow, ceLow, badBus, wrLog, timedOut);
        lastWrLog = wrLog;
        checkOutput({tag, "/timeout"}, 64'(timedOut), 64'd0);
        checkOutput({tag, "/latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "/err"}, 64'(sawErr), 64'(isErr));
        checkOutput({tag, "/read_data"}, 64'(rd), 64'(lastRead));
        checkOutput({tag, "/we_cycles"}, 64'(weLow), (isWr && !isErr) ? 64'd2 : 64'd0);
        checkOutput({tag, "/oe_cycles"}, 64'(oeLow), (!isWr && !isErr) ? 64'd4 : 64'd0);
        checkOutput({tag, "/ce_cycles"}, 64'(ceLow), isErr ? 64'd0 : (isWr ? 64'd2 : 64'd4));
        checkOutput({tag, "/bus_rules"}, 64'(badBus), 64'd0);
    endtask

    // One full-width access on the 64-bit instance.
    task automatic applyStimulus64(input bit isWr, input logic [31:0] addr, input logic [63:0] data,
                                   output int lat, output logic sawErr, output logic [63:0] rd);
        lat = 0; sawErr = 1'b0; rd = '0;
        @(negedge clk);
        wrEn64 = isWr; rdEn64 = !isWr; address64 = addr; writeData64 = data; byteEn64 = 8'hFF;
        @(posedge clk);
        #1;
        wrEn64 = 1'b0; rdEn64 = 1'b0;
        while (1) begin
            @(negedge clk);
            if (ready64) begin
                sawErr = err64;
                rd = readData64;
                break;
            end
            if (lat >= 40) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic sawErr;
        logic [63:0] rd64;
        logic [31:0] rAddr;
        int cat;

        rst_n = 1'b0;
        wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0; byteEn = '0;
        wrEn64 = 1'b0; rdEn64 = 1'b0; address64 = '0; writeData64 = '0; byteEn64 = '0;
        lastRead = '0;
        lastWrLog = '0;

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset/strobes", 64'({weN, oeN, ceN, ubN, lbN}), 64'h1F);
        checkOutput("reset/sram_addr", 64'(sramAddr), 64'd0);
        checkOutput("reset/read_data", 64'(readData), 64'd0);
        checkOutput("reset/err", 64'(err), 64'd0);
        checkOutput("reset/ready_idle", 64'(ready), 64'd1);
        rst_n = 1'b1;

        $display("[TB] full write and readback");
        runAccess("wr_full", 1'b1, 32'd1024, 32'hDEADBEEF, 4'hF);
        checkOutput("wr_full/sram0", 64'(sram[0]), 64'hBEEF);
        checkOutput("wr_full/sram1", 64'(sram[1]), 64'hDEAD);
        checkOutput("wr_full/lanes", 64'(lastWrLog), 64'h00);
        runAccess("rd_full", 1'b0, 32'd1024, 32'h0, 4'h0);

        $display("[TB] partial write");
        runAccess("wr_part", 1'b1, 32'd1028, 32'h11223344, 4'b0100);
        checkOutput("wr_part/lanes", 64'(lastWrLog), 64'h0E);
        checkOutput("wr_part/sram2", 64'(sram[2]), 64'h0000);
        checkOutput("wr_part/sram3", 64'(sram[3]), 64'h0022);
        runAccess("rd_part", 1'b0, 32'd1028, 32'h0, 4'h0);

        $display("[TB] range errors and top of memory");
        runAccess("err_low", 1'b1, 32'd1020, 32'hCAFEF00D, 4'hF);
        runAccess("err_high", 1'b0, BASE + SRAM_BYTES, 32'h0, 4'h0);
        runAccess("wr_top", 1'b1, BASE + SRAM_BYTES - 32'd4, 32'hA5A55A5A, 4'hF);
        runAccess("rd_top", 1'b0, BASE + SRAM_BYTES - 32'd2, 32'h0, 4'h0);

        $display("[TB] reset during a write burst");
        @(negedge clk);
        wrEn = 1'b1; address = 32'd1044; writeData = 32'h12345678; byteEn = 4'hF;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid/we_n", 64'(weN), 64'd1);
        checkOutput("rst_mid/ce_n", 64'(ceN), 64'd1);
        checkOutput("rst_mid/err", 64'(err), 64'd0);
        checkOutput("rst_mid/read_data", 64'(readData), 64'd0);
        lastRead = '0;
        refMem[20] = 8'h78;
        refMem[21] = 8'h56;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_mid/beat1_untouched", 64'(sram[11]), 64'h0000);
        runAccess("rd_after_rst", 1'b0, 32'd1044, 32'h0, 4'h0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            cat = int'($urandom_range(0, 9));
            if (cat <= 5)      rAddr = BASE + 32'($urandom_range(0, 63));
            else if (cat <= 7) rAddr = BASE + SRAM_BYTES - 32'd8 + 32'($urandom_range(0, 15));
            else if (cat == 8) rAddr = 32'($urandom_range(0, 1023));
            else               rAddr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            runAccess($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), rAddr, $urandom,
                      4'($urandom_range(0, 15)));
        end

        $display("[TB] 64-bit width, no settle wait");
        applyStimulus64(1'b1, 32'd1032, 64'h0123456789ABCDEF, lat, sawErr, rd64);
        checkOutput("w64/latency", 64'(lat), 64'd5);
        checkOutput("w64/err", 64'(sawErr), 64'd0);
        checkOutput("w64/hw4", 64'(sram64[4]), 64'hCDEF);
        checkOutput("w64/hw5", 64'(sram64[5]), 64'h89AB);
        checkOutput("w64/hw6", 64'(sram64[6]), 64'h4567);
        checkOutput("w64/hw7", 64'(sram64[7]), 64'h0123);
        applyStimulus64(1'b0, 32'd1032, 64'h0, lat, sawErr, rd64);
        checkOutput("r64/latency", 64'(lat), 64'd9);
        checkOutput("r64/read_data", rd64, 64'h0123456789ABCDEF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
